// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - radix-2 non-restoring signed divider, one quotient bit per clock
// Optional zero-divisor short cut enabled by macro DIV_ZERO_CHECK_EN.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH:0]   r_r;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;

    logic [WIDTH-1:0] w_abs_dvd;
    logic [WIDTH-1:0] w_abs_dvs;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_b_ext;
    logic [WIDTH:0]   w_r_iter;
    logic [WIDTH-1:0] w_rem_mag;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

`ifdef DIV_ZERO_CHECK_EN
    logic r_zero;
    logic r_div_zero;
    assign div_zero = r_div_zero;
`else
    assign div_zero = 1'b0;
`endif

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

    // Magnitudes: the most-negative value maps onto itself, read as unsigned.
    assign w_abs_dvd = dividend[WIDTH-1] ? ({WIDTH{1'b0}} - dividend) : dividend;
    assign w_abs_dvs = divisor[WIDTH-1]  ? ({WIDTH{1'b0}} - divisor)  : divisor;

    assign w_b_ext   = {1'b0, r_b};
    assign w_shift   = {r_r[WIDTH-1:0], r_a[r_cnt]};
    assign w_r_iter  = r_r[WIDTH] ? (w_shift + w_b_ext) : (w_shift - w_b_ext);
    // Final restore step; the result is non-negative and below B, so WIDTH bits suffice.
    assign w_rem_mag = r_r[WIDTH] ? (r_r[WIDTH-1:0] + r_b) : r_r[WIDTH-1:0];

    always_comb begin
        w_quot = r_sign_q ? ({WIDTH{1'b0}} - r_q) : r_q;
        w_rem  = r_sign_r ? ({WIDTH{1'b0}} - w_rem_mag) : w_rem_mag;
`ifdef DIV_ZERO_CHECK_EN
        if (r_zero) begin
            w_quot = '0;
            w_rem  = '0;
        end
`endif
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_CHECK_EN
                    w_next = (divisor == '0) ? S_FIX : S_ITER;
`else
                    w_next = S_ITER;
`endif
                end
            end
            S_ITER:  if (r_cnt == '0) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_r        <= '0;
            r_q        <= '0;
            r_cnt      <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            quotient   <= '0;
            remainder  <= '0;
`ifdef DIV_ZERO_CHECK_EN
            r_zero     <= 1'b0;
            r_div_zero <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= w_abs_dvd;
                        r_b      <= w_abs_dvs;
                        r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_sign_r <= dividend[WIDTH-1];
                        r_r      <= '0;
                        r_q      <= '0;
                        r_cnt    <= CW'(WIDTH - 1);
`ifdef DIV_ZERO_CHECK_EN
                        r_zero   <= (divisor == '0);
`endif
                    end
                end
                S_ITER: begin
                    r_r        <= w_r_iter;
                    r_q[r_cnt] <= ~w_r_iter[WIDTH];
                    r_cnt      <= r_cnt - 1'b1;
                end
                S_FIX: begin
                    quotient   <= w_quot;
                    remainder  <= w_rem;
`ifdef DIV_ZERO_CHECK_EN
                    r_div_zero <= r_zero;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
